// File: rtl/button_gesture_decoder_if.sv
// rtl/button_gesture_decoder_if.sv - button level, enables and gesture outputs
// The master side drives the debounced level and enables; the decoder is the slave.
interface button_gesture_decoder_if;
  logic       debouncedActiveHigh;
  logic       enableRepeat;
  logic       enableDoubleClick;
  logic       shortPress;
  logic       longPress;
  logic       repeatPulse;
  logic       doubleClick;
  logic       pressed;
  logic [7:0] gestureCount;

  modport master (
    output debouncedActiveHigh, enableRepeat, enableDoubleClick,
    input  shortPress, longPress, repeatPulse, doubleClick, pressed, gestureCount
  );

  modport slave (
    input  debouncedActiveHigh, enableRepeat, enableDoubleClick,
    output shortPress, longPress, repeatPulse, doubleClick, pressed, gestureCount
  );
endinterface

// File: rtl/button_gesture_decoder.sv
// rtl/button_gesture_decoder.sv - classifies debounced presses into gestures
// One shared counter times long presses, auto-repeat and the double-click window.
module button_gesture_decoder #(
  parameter int COUNTER_WIDTH       = 26,
  parameter int LONG_PRESS_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES       = 12500000,
  parameter int DOUBLE_CLICK_WINDOW = 25000000
) (
  input logic clk,
  input logic resetActiveLow,
  button_gesture_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    HELD        = 3'd1,
    LONG        = 3'd2,
    WAIT_SECOND = 3'd3,
    SECOND_HELD = 3'd4
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] ONE        = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] LONG_LIMIT = COUNTER_WIDTH'(LONG_PRESS_CYCLES);
  localparam logic [COUNTER_WIDTH-1:0] REP_LIMIT  = COUNTER_WIDTH'(REPEAT_CYCLES);
  localparam logic [COUNTER_WIDTH-1:0] DC_LIMIT   = COUNTER_WIDTH'(DOUBLE_CLICK_WINDOW);

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] count;
  logic [COUNTER_WIDTH-1:0] countNext;
  logic                     prev;
  logic                     level;

  assign level     = bus.debouncedActiveHigh;
  assign countNext = count + ONE;

  // prev resets high so a button held through reset must be released before it counts
  always_ff @(posedge clk or negedge resetActiveLow) begin
    if (!resetActiveLow) begin
      state            <= IDLE;
      count            <= '0;
      prev             <= 1'b1;
      bus.shortPress   <= 1'b0;
      bus.longPress    <= 1'b0;
      bus.repeatPulse  <= 1'b0;
      bus.doubleClick  <= 1'b0;
      bus.pressed      <= 1'b0;
      bus.gestureCount <= 8'd0;
    end else begin
      prev            <= level;
      bus.shortPress  <= 1'b0;
      bus.longPress   <= 1'b0;
      bus.repeatPulse <= 1'b0;
      bus.doubleClick <= 1'b0;
      case (state)
        IDLE: begin
          if (level && !prev) begin
            state       <= HELD;
            count       <= ONE;
            bus.pressed <= 1'b1;
          end
        end
        HELD: begin
          if (level) begin
            if (countNext == LONG_LIMIT) begin
              bus.longPress    <= 1'b1;
              bus.gestureCount <= bus.gestureCount + 8'd1;
              state            <= LONG;
              count            <= '0;
            end else begin
              count <= countNext;
            end
          end else if (bus.enableDoubleClick) begin
            state       <= WAIT_SECOND;
            count       <= ONE;
            bus.pressed <= 1'b0;
          end else begin
            bus.shortPress   <= 1'b1;
            bus.gestureCount <= bus.gestureCount + 8'd1;
            state            <= IDLE;
            bus.pressed      <= 1'b0;
          end
        end
        LONG: begin
          if (!level) begin
            state       <= IDLE;
            bus.pressed <= 1'b0;
          end else if (bus.enableRepeat) begin
            if (countNext == REP_LIMIT) begin
              bus.repeatPulse <= 1'b1;
              count           <= '0;
            end else begin
              count <= countNext;
            end
          end else begin
            count <= '0;
          end
        end
        WAIT_SECOND: begin
          // a press arriving on the expiry edge still wins as a double click
          if (level) begin
            bus.doubleClick  <= 1'b1;
            bus.gestureCount <= bus.gestureCount + 8'd1;
            state            <= SECOND_HELD;
            bus.pressed      <= 1'b1;
          end else if (countNext == DC_LIMIT) begin
            bus.shortPress   <= 1'b1;
            bus.gestureCount <= bus.gestureCount + 8'd1;
            state            <= IDLE;
          end else begin
            count <= countNext;
          end
        end
        SECOND_HELD: begin
          if (!level) begin
            state       <= IDLE;
            bus.pressed <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          count       <= '0;
          bus.pressed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// tb/tb_button_gesture_decoder.sv - randomized and directed gesture checks
// Expected strobes come from a press/gap run-length model of the gesture rules.
module tb_button_gesture_decoder;
  localparam int LP = 20;
  localparam int RP = 5;
  localparam int DW = 10;

  logic clk = 1'b0;
  logic resetActiveLow;
  int   total = 0;
  int   bad = 0;
  logic [7:0] expGc;
  int   pressLen[$];
  int   gapLen[$];

  button_gesture_decoder_if bus();

  button_gesture_decoder #(
    .COUNTER_WIDTH(8),
    .LONG_PRESS_CYCLES(LP),
    .REPEAT_CYCLES(RP),
    .DOUBLE_CLICK_WINDOW(DW)
  ) dut (
    .clk(clk),
    .resetActiveLow(resetActiveLow),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {bus.shortPress, bus.longPress, bus.repeatPulse, bus.doubleClick};
  endfunction

  // Bits of an event vector: 3 short, 2 long, 1 repeat, 0 double click.
  task automatic playTrial(input bit dc, input bit rep);
    bit         lvl[$];
    logic [3:0] ev[$];
    logic [3:0] e;
    int         s;
    bit         waiting;
    foreach (pressLen[i]) begin
      repeat (pressLen[i]) lvl.push_back(1'b1);
      repeat (gapLen[i])   lvl.push_back(1'b0);
    end
    foreach (lvl[k]) ev.push_back(4'b0000);
    s = 0;
    waiting = 1'b0;
    foreach (pressLen[i]) begin
      if (waiting) begin
        ev[s] = 4'b0001;
        waiting = 1'b0;
      end else if (pressLen[i] >= LP) begin
        ev[s + LP - 1] = 4'b0100;
        if (rep)
          for (int t = s + LP - 1 + RP; t <= s + pressLen[i] - 1; t += RP) ev[t] = 4'b0010;
      end else if (!dc) begin
        ev[s + pressLen[i]] = 4'b1000;
      end else if (gapLen[i] >= DW) begin
        ev[s + pressLen[i] + DW - 1] = 4'b1000;
      end else begin
        waiting = 1'b1;
      end
      s += pressLen[i] + gapLen[i];
    end
    bus.enableDoubleClick = dc;
    bus.enableRepeat = rep;
    foreach (lvl[n]) begin
      @(negedge clk);
      bus.debouncedActiveHigh = lvl[n];
      @(posedge clk);
      #1;
      e = ev[n];
      if (e[3] || e[2] || e[0]) expGc = expGc + 8'd1;
      check("strobes", 32'(strobes()), 32'(e));
      check("pressed", 32'(bus.pressed), 32'(lvl[n]));
      check("gestureCount", 32'(bus.gestureCount), 32'(expGc));
    end
    pressLen.delete();
    gapLen.delete();
  endtask

  task automatic addPress(input int l, input int g);
    pressLen.push_back(l);
    gapLen.push_back(g);
  endtask

  task automatic idleLow(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.debouncedActiveHigh = 1'b0;
    end
  endtask

  initial begin
    resetActiveLow = 1'b0;
    bus.debouncedActiveHigh = 1'b0;
    bus.enableRepeat = 1'b0;
    bus.enableDoubleClick = 1'b0;
    expGc = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_strobes", 32'(strobes()), 32'd0);
    check("reset_pressed", 32'(bus.pressed), 32'd0);
    check("reset_count", 32'(bus.gestureCount), 32'd0);
    @(negedge clk);
    resetActiveLow = 1'b1;
    idleLow(3);

    // 256 short presses wrap the gesture counter back to zero
    for (int i = 0; i < 256; i++) addPress(2, (i == 255) ? 12 : 2);
    playTrial(1'b0, 1'b0);
    check("wrap_count", 32'(bus.gestureCount), 32'd0);

    // directed gestures
    addPress(8, 12);
    playTrial(1'b0, 1'b0);
    addPress(8, 12);
    playTrial(1'b1, 1'b0);
    addPress(8, 4);  addPress(3, 12);
    addPress(8, 9);  addPress(3, 12);
    addPress(8, 10); addPress(3, 12);
    playTrial(1'b1, 1'b0);
    addPress(41, 12);
    playTrial(1'b0, 1'b1);
    addPress(41, 12);
    playTrial(1'b1, 1'b0);

    // randomized press/gap sequences
    for (int t = 0; t < 30; t++) begin
      int np;
      np = int'($urandom_range(1, 4));
      for (int p = 0; p < np; p++) begin
        int l;
        case ($urandom_range(0, 2))
          0:       l = int'($urandom_range(1, 8));
          1:       l = int'($urandom_range(18, 27));
          default: l = int'($urandom_range(35, 45));
        endcase
        addPress(l, (p == np - 1) ? int'($urandom_range(12, 14)) : int'($urandom_range(1, 14)));
      end
      playTrial(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset at high sample 15 of a hold, then the held button is ignored
    bus.enableDoubleClick = 1'b0;
    bus.enableRepeat = 1'b1;
    if (expGc == 8'd0) begin
      addPress(3, 12);
      playTrial(1'b0, 1'b1);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.debouncedActiveHigh = 1'b1;
      @(posedge clk);
      #1;
      check("hold_strobes", 32'(strobes()), 32'd0);
    end
    #1;
    resetActiveLow = 1'b0;
    #1;
    check("midreset_strobes", 32'(strobes()), 32'd0);
    check("midreset_pressed", 32'(bus.pressed), 32'd0);
    check("midreset_count", 32'(bus.gestureCount), 32'd0);
    repeat (2) @(negedge clk);
    resetActiveLow = 1'b1;
    expGc = 8'd0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      check("held_strobes", 32'(strobes()), 32'd0);
      check("held_pressed", 32'(bus.pressed), 32'd0);
    end
    idleLow(3);
    addPress(8, 12);
    playTrial(1'b0, 1'b0);
    check("after_release_count", 32'(bus.gestureCount), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/button_gesture_decoder.md
# button_gesture_decoder

Downstream consumer of the falling-edge pushbutton debouncer. Takes its synchronous, active-high debounced level and classifies each press as a short press, long press, double click, or auto-repeat. Emits single-cycle strobes and a wrapping gesture counter to the front-panel / control-register logic.

## Interface
- `COUNTER_WIDTH`, 26: width of the shared timing counter. Every cycle parameter below must fit in it.
- `LONG_PRESS_CYCLES`, 50000000: consecutive high samples that make a long press. Must be ≥ 2.
- `REPEAT_CYCLES`, 12500000: high samples between auto-repeat pulses after a long press. Must be ≥ 2.
- `DOUBLE_CLICK_WINDOW`, 25000000: low samples after a short release during which a second press counts as a double click. Must be ≥ 2.
- `clk`  input  1  sole clock.
- `resetActiveLow`  input  1  asynchronous, active-low reset.
- `debouncedActiveHigh`  input  1  debouncer output, already synchronous to `clk`.
- `enableRepeat`  input  1  allows `repeatPulse` generation while in LONG.
- `enableDoubleClick`  input  1  enables double-click detection. When low, short presses report immediately on release.
- `shortPress`  output  1  one-cycle strobe.
- `longPress`  output  1  one-cycle strobe.
- `repeatPulse`  output  1  one-cycle strobe.
- `doubleClick`  output  1  one-cycle strobe.
- `pressed`  output  1  level; high while state is HELD, LONG or SECOND_HELD.
- `gestureCount`  output  8  increments on each `shortPress`, `longPress` or `doubleClick`. Wraps 255→0. Does not count repeats.

## Operation
- One clock domain and one shared counter `count`.
- `prev` is a registered copy of the input, used for rising-edge detection. "Sample" means the value of `debouncedActiveHigh` at a rising edge of `clk`.
- Reset (asynchronous, active-low) sets:
  - state = IDLE, `count` = 0, `prev` = 1
  - all strobes, `pressed` and `gestureCount` = 0
- Because `prev` resets to 1, a button held through reset release is ignored until it has been released once.
- State transitions:
  - **IDLE:** on a high sample with `prev`=0 → HELD, `count`←1.
  - **HELD:**
    - High sample: if `count`+1 == `LONG_PRESS_CYCLES` → `longPress`, LONG, `count`←0. Otherwise `count`++.
    - Low sample with `enableDoubleClick`=1 → WAIT_SECOND, `count`←1.
    - Low sample with `enableDoubleClick`=0 → `shortPress`, IDLE.
  - **LONG:**
    - Low sample → IDLE, with no strobe.
    - High sample with `enableRepeat`=1: if `count`+1 == `REPEAT_CYCLES` → `repeatPulse`, `count`←0. Otherwise `count`++.
    - High sample with `enableRepeat`=0: `count` held at 0.
  - **WAIT_SECOND:**
    - High sample → `doubleClick`, SECOND_HELD.
    - Low sample: if `count`+1 == `DOUBLE_CLICK_WINDOW` → `shortPress`, IDLE. Otherwise `count`++.
  - **SECOND_HELD:** low sample → IDLE. A second press never produces a long press or repeats.
- Enable inputs are read only at the decision edge. Changing `enableDoubleClick` while in WAIT_SECOND does not abort the window.
- At most one strobe is high in any cycle.
- Only four of the 3-bit state codes are used by name plus SECOND_HELD. Any unused code recovers to IDLE on the next edge.

## Timing
- Every output is registered. A strobe is high for exactly the one cycle following the edge that decides it.
- Latencies, measured in samples:
  - `longPress`: on the edge of the `LONG_PRESS_CYCLES`-th consecutive high sample.
  - `repeatPulse`: every `REPEAT_CYCLES` high samples after that edge.
  - `shortPress` (double-click disabled): on the first low sample.
  - `shortPress` (double-click enabled): on the `DOUBLE_CLICK_WINDOW`-th consecutive low sample.
  - `doubleClick`: on the first high sample in WAIT_SECOND.
- If a high sample arrives on the edge where the window would expire, the high sample wins and `doubleClick` is issued.
- `pressed` follows state and is valid one cycle after the deciding edge.
- `gestureCount` updates on the same edge as the strobe it counts.
- Reset asserted mid-gesture: all outputs drop immediately and no strobe is issued for the interrupted gesture.

## Test plan
Bench parameters: `COUNTER_WIDTH`=8, `LONG_PRESS_CYCLES`=20, `REPEAT_CYCLES`=5, `DOUBLE_CLICK_WINDOW`=10.
1. `enableDoubleClick`=0, input high for 8 cycles → `shortPress` one cycle, latched at the first low sample; `gestureCount`=1; no other strobes.
2. `enableDoubleClick`=1, input high 8 cycles then low → `shortPress` one cycle, latched at the 10th low sample; `pressed` low from the first low sample.
3. `enableDoubleClick`=1, input high 8, low 4, high 3 → `doubleClick` at the first high sample of the second press; no `shortPress`; `gestureCount` +1 only. Repeat with low 9 and low exactly 10 → the 9-low case gives `doubleClick`; the 10-low case gives `shortPress` and the second press starts a new HELD.
4. `enableRepeat`=1, input held 41 cycles → `longPress` at high sample 20; `repeatPulse` at samples 25, 30, 35, 40; nothing on release; `gestureCount` +1. With `enableRepeat`=0 → no `repeatPulse`.
5. Input high across reset deassertion for 30 cycles → no strobes and `pressed`=0; then release and press for 8 cycles (`enableDoubleClick`=0) → exactly one `shortPress`.
6. 256 short presses → `gestureCount` wraps to 0. Reset asserted at high sample 15 of a hold → all outputs 0 immediately and no `longPress`.
